btn_event_ctrl: RTL and testbench
=================================

// Module: btn_event_ctrl
// PURPOSE
//  Sits between the per-button debouncers and the watch mode/set FSM. Takes debounced button
//  levels and classifies each press as SHORT, LONG or REPEAT. Arbitrates events from all buttons
//  round-robin onto one valid/ready event port, so the watch FSM sees one ordered stream.
// PARAMETERS
//  NUM_BTN    4       number of buttons (2..8)
//  TICK_DIV   100000  clk cycles per 1 ms tick (100 MHz -> 1 kHz)
//  LONG_MS    1000    hold time in ticks before LONG is issued
//  REPEAT_MS  200     REPEAT period in ticks after LONG
// PORTS
//  clk          in   1                 system clock
//  rst          in   1                 asynchronous, active-high reset
//  i_btn_level  in   NUM_BTN           debounced button levels, 1 = pressed, synchronous to clk
//  o_evt_valid  out  1                 event available
//  i_evt_ready  in   1                 consumer accepts the event on a clk edge where valid & ready
//  o_evt_id     out  $clog2(NUM_BTN)   index of the button that produced the event
//  o_evt_type   out  2                 01 SHORT, 10 LONG, 11 REPEAT; 00 never driven while valid
//  o_evt_drop   out  1                 1-cycle pulse: an event was lost (its button's slot was full)
// BEHAVIOUR
//  - Reset: all outputs 0, tick divider 0, all button FSMs IDLE, slots empty, RR pointer 0.
//  - Tick: one free-running divider; tick is high 1 clk every TICK_DIV clks. Hold counters
//    advance only on tick cycles.
//  - Per-button FSM:
//    IDLE    : level=1 -> PRESSED, cnt=0.
//    PRESSED : level=0 -> emit SHORT, go IDLE.
//              tick & cnt==LONG_MS-1 -> emit LONG, go LONG, cnt=0; otherwise tick -> cnt++.
//    LONG    : level=0 -> go IDLE, no event.
//              tick & cnt==REPEAT_MS-1 -> emit REPEAT, cnt=0, stay (see CONFIGURATION).
//  - Release is checked before the tick in the same cycle: level=0 always wins.
//  - Counter width is $clog2(max(LONG_MS,REPEAT_MS)); a counter never wraps.
//  - Slots: one pending slot {full, type} per button. An emit loads the slot on the next edge.
//    If the slot is full and is not granted that cycle, the new event is discarded and
//    o_evt_drop pulses. A grant and an emit on the same button in the same cycle: the slot
//    reloads with the new event, no drop.
//  - Output register: loads when it is empty or is being consumed this cycle (valid & ready).
//    The grant goes to the first full slot searching from RR pointer+1 cyclically. The pointer
//    then moves to the granted index.
//  - id and type are held stable while valid & !ready.
//  - Latency: emit in cycle t -> slot full at t+1 -> o_evt_valid at t+2 (output idle).
//    Back-to-back throughput: 1 event/clk with ready held high.
//  - Level change on any button mid-count is handled per FSM; other buttons are unaffected.
//  - rst mid-operation: pending and in-flight events are lost; no event is issued on release
//    after reset.
// CONFIGURATION
//  BTN_EVT_REPEAT_EN defined: LONG state issues REPEAT every REPEAT_MS ticks while held.
//  Not defined: LONG state only waits for release. REPEAT (type 11) is never produced and the
//  REPEAT counter logic is absent.
// STRUCTURE
//  - Package btn_evt_pkg (include file in Verilog flow) holds:
//    EVT_NONE/EVT_SHORT/EVT_LONG/EVT_REPEAT codes and the FSM state encodings
//    ST_IDLE/ST_PRESSED/ST_LONG. The watch FSM imports it to decode o_evt_type.
//  - Sub-module btn_press_fsm holds one button's FSM, counter and emit/type outputs.
//    It is instantiated NUM_BTN times in a generate loop.
//  - The tick divider, slots, RR arbiter and output register stay in btn_event_ctrl.
// TESTING (bench: NUM_BTN=4, TICK_DIV=10, LONG_MS=5, REPEAT_MS=2, ready=1 unless noted)
//  1. btn0 high 20 clk, then low -> one event {id0, SHORT} 2 clk after the fall; no drop.
//  2. btn1 held 100 clk -> LONG after the 5th tick.
//     With BTN_EVT_REPEAT_EN: REPEAT every 2 ticks until release; no event on release.
//     Without it: no REPEAT.
//  3. btn0 and btn2 released in the same clk -> id0 then id2 on consecutive valid cycles.
//     Repeat with RR pointer=0 -> order is id2, then id0.
//  4. ready=0, btn3 gives SHORT twice (2nd press completes before the 1st is accepted)
//     -> valid held stable with id3/SHORT.
//     3rd SHORT while the slot is full -> o_evt_drop pulses once.
//     ready=1 -> exactly 2 events delivered.
//  5. Release in the same clk as the LONG-threshold tick -> SHORT only, no LONG.
//  6. Assert rst with btn1 in LONG and an event valid -> all outputs 0 next clk.
//     Release after rst drops -> no event.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared event codes and button FSM encodings for the button event path.
// The watch mode/set FSM imports this package to decode o_evt_type.
package btn_evt_pkg;

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_SHORT  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_REPEAT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } btn_state_e;

  function automatic int cnt_w(int a, int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int rr_idx(int base, int k, int n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/btn_press_fsm.sv
// One button's press classifier: SHORT on release, LONG after a hold and,
// with BTN_EVT_REPEAT_EN defined, REPEAT while the hold continues.
module btn_press_fsm
  import btn_evt_pkg::*;
#(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       level_i,
  output logic       emit_o,
  output logic [1:0] type_o
);

  localparam int CW = cnt_w(LONG_MS, REPEAT_MS);
  localparam logic [CW-1:0] LONG_MAX = CW'(LONG_MS - 1);
`ifdef BTN_EVT_REPEAT_EN
  localparam logic [CW-1:0] REP_MAX = CW'(REPEAT_MS - 1);
`endif

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q;

  // lvl_q resets high so a button held through reset must be released
  // and pressed again before it is counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= level_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit_o  = 1'b0;
    type_o  = EVT_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (level_i && !lvl_q) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end
      end
      ST_PRESSED: begin
        if (!level_i) begin
          emit_o  = 1'b1;
          type_o  = EVT_SHORT;
          state_d = ST_IDLE;
        end else if (tick_i) begin
          if (cnt_q == LONG_MAX) begin
            emit_o  = 1'b1;
            type_o  = EVT_LONG;
            state_d = ST_LONG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_LONG: begin
        if (!level_i) begin
          state_d = ST_IDLE;
        end
`ifdef BTN_EVT_REPEAT_EN
        else if (tick_i) begin
          if (cnt_q == REP_MAX) begin
            emit_o = 1'b1;
            type_o = EVT_REPEAT;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Button event classifier and round-robin arbiter onto one valid/ready port.
// Define BTN_EVT_REPEAT_EN to enable REPEAT events while a button stays held.
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int  NUM_BTN   = 4,
  parameter int  TICK_DIV  = 100000,
  parameter int  LONG_MS   = 1000,
  parameter int  REPEAT_MS = 200,
  localparam int IDW       = $clog2(NUM_BTN)
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] i_btn_level,
  output logic               o_evt_valid,
  input  logic               i_evt_ready,
  output logic [IDW-1:0]     o_evt_id,
  output logic [1:0]         o_evt_type,
  output logic               o_evt_drop
);

  localparam int DW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          tick;

  logic [NUM_BTN-1:0] emit;
  logic [1:0]         etype [NUM_BTN];

  logic [NUM_BTN-1:0]      full_q, full_d;
  logic [NUM_BTN-1:0][1:0] typ_q, typ_d;
  logic [NUM_BTN-1:0]      drop_vec;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] idx, gnt_idx;
  logic [1:0]     gnt_typ;
  logic           gnt_any, load;

  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  logic [1:0]     type_q, type_d;
  logic           drop_q, drop_d;

  assign tick  = (div_q == DIV_MAX);
  assign div_d = tick ? '0 : div_q + 1'b1;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_press_fsm #(
      .LONG_MS  (LONG_MS),
      .REPEAT_MS(REPEAT_MS)
    ) u_fsm (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick),
      .level_i(i_btn_level[g]),
      .emit_o (emit[g]),
      .type_o (etype[g])
    );
  end

  assign load = !valid_q || i_evt_ready;

  // First full slot after the pointer wins, wrapping around.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    gnt_typ = EVT_NONE;
    idx     = '0;
    if (load) begin
      for (int k = 1; k <= NUM_BTN; k++) begin
        idx = IDW'(rr_idx(int'(ptr_q), k, NUM_BTN));
        if (!gnt_any && full_q[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = idx;
          gnt_typ = typ_q[idx];
        end
      end
    end
  end

  always_comb begin
    full_d   = full_q;
    typ_d    = typ_q;
    drop_vec = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (gnt_any && (IDW'(i) == gnt_idx)) begin
        full_d[i] = 1'b0;
      end
      if (emit[i]) begin
        if (!full_q[i] || (gnt_any && (IDW'(i) == gnt_idx))) begin
          full_d[i] = 1'b1;
          typ_d[i]  = etype[i];
        end else begin
          drop_vec[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    type_d  = type_q;
    ptr_d   = ptr_q;
    drop_d  = |drop_vec;
    if (load) begin
      valid_d = gnt_any;
      if (gnt_any) begin
        id_d   = gnt_idx;
        type_d = gnt_typ;
        ptr_d  = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      full_q  <= '0;
      typ_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      type_q  <= EVT_NONE;
      drop_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      full_q  <= full_d;
      typ_q   <= typ_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      type_q  <= type_d;
      drop_q  <= drop_d;
    end
  end

  assign o_evt_valid = valid_q;
  assign o_evt_id    = id_q;
  assign o_evt_type  = type_q;
  assign o_evt_drop  = drop_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Scoreboard bench for btn_event_ctrl: directed presses push expected
// events; a negedge monitor pops and compares each accepted event.
module tb_btn_event_ctrl;
  import btn_evt_pkg::*;

  localparam int NB = 4;
  localparam int TD = 10;
  localparam int LM = 5;
  localparam int RM = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] lvl = '0;
  logic          ready = 1'b1;
  logic          valid;
  logic [1:0]    id;
  logic [1:0]    typ;
  logic          drop;

  btn_event_ctrl #(
    .NUM_BTN  (NB),
    .TICK_DIV (TD),
    .LONG_MS  (LM),
    .REPEAT_MS(RM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_btn_level(lvl),
    .o_evt_valid(valid),
    .i_evt_ready(ready),
    .o_evt_id   (id),
    .o_evt_type (typ),
    .o_evt_drop (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [1:0] typ;
    int         due;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ph = 0;
  int drops = 0;
  int got = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference phase of the free-running 1 ms tick divider.
  always @(posedge clk or posedge rst)
    if (rst) ph <= 0;
    else ph <= (ph == TD - 1) ? 0 : ph + 1;

  task automatic chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic push(int i, logic [1:0] t, int d);
    exp_t e;
    e.id  = 2'(i);
    e.typ = t;
    e.due = d;
    q.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ph(int p);
    int k;
    k = 0;
    step(1);
    while (ph != p && k < 3 * TD) begin
      step(1);
      k++;
    end
    chk("tick_phase", ph, p);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 300) begin
      step(1);
      k++;
    end
    chk("drain", q.size(), 0);
    step(5);
  endtask

  // Monitor: accepted events vs scoreboard, stability while stalled.
  initial begin
    logic       hold;
    logic [1:0] hid;
    logic [1:0] htyp;
    exp_t       e;
    hold = 1'b0;
    hid  = '0;
    htyp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", int'(valid), 1);
          chk("hold_id", int'(id), int'(hid));
          chk("hold_type", int'(typ), int'(htyp));
        end
        if (drop) drops++;
        if (valid && ready) begin
          got++;
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_evt: got id%0d type%0d want none",
                     id, typ);
          end else begin
            e = q.pop_front();
            chk("evt_id", int'(id), int'(e.id));
            chk("evt_type", int'(typ), int'(e.typ));
            if (e.due >= 0) chk("evt_cycle", cyc, e.due);
          end
        end
        hold = valid && !ready;
        hid  = id;
        htyp = typ;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int g0;

    @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_id", int'(id), 0);
    chk("rst_type", int'(typ), 0);
    chk("rst_drop", int'(drop), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // SHORT press on btn0, event two cycles after the release
    step(2);
    lvl[0] = 1'b1;
    step(20);
    lvl[0] = 1'b0;
    push(0, EVT_SHORT, cyc + 2);
    drain();
    chk("t1_drop", drops, 0);

    // btn1 held 100 clk, aligned to the tick phase
    wait_ph(0);
    c0 = cyc;
    lvl[1] = 1'b1;
    push(1, EVT_LONG, c0 + 51);
`ifdef BTN_EVT_REPEAT_EN
    push(1, EVT_REPEAT, c0 + 71);
    push(1, EVT_REPEAT, c0 + 91);
`endif
    step(100);
    lvl[1] = 1'b0;
    drain();

    // Stalled consumer: two SHORTs held, third one dropped
    g0 = got;
    ready = 1'b0;
    step(2);
    for (int i = 0; i < 3; i++) begin
      lvl[3] = 1'b1;
      step(3);
      lvl[3] = 1'b0;
      if (i < 2) push(3, EVT_SHORT, -1);
      step(6);
    end
    chk("t4_drop", drops, 1);
    ready = 1'b1;
    drain();
    chk("t4_got", got - g0, 2);

    // Simultaneous release, pointer at 3: id0 then id2
    lvl[0] = 1'b1;
    lvl[2] = 1'b1;
    step(5);
    lvl[0] = 1'b0;
    lvl[2] = 1'b0;
    push(0, EVT_SHORT, cyc + 2);
    push(2, EVT_SHORT, cyc + 3);
    drain();

    // Move pointer to 0, then simultaneous release gives id2 then id0
    lvl[0] = 1'b1;
    step(3);
    lvl[0] = 1'b0;
    push(0, EVT_SHORT, cyc + 2);
    drain();
    lvl[0] = 1'b1;
    lvl[2] = 1'b1;
    step(5);
    lvl[0] = 1'b0;
    lvl[2] = 1'b0;
    push(2, EVT_SHORT, cyc + 2);
    push(0, EVT_SHORT, cyc + 3);
    drain();

    // Release on the LONG-threshold tick: SHORT only
    wait_ph(0);
    lvl[2] = 1'b1;
    step(49);
    lvl[2] = 1'b0;
    push(2, EVT_SHORT, cyc + 2);
    drain();

    // Release one cycle after the threshold tick: LONG, nothing on release
    wait_ph(0);
    c0 = cyc;
    lvl[2] = 1'b1;
    push(2, EVT_LONG, c0 + 51);
    step(50);
    lvl[2] = 1'b0;
    drain();
    chk("drop_total", drops, 1);

    // Reset with btn1 in LONG and a stalled event
    ready = 1'b0;
    wait_ph(0);
    lvl[1] = 1'b1;
    step(55);
    chk("t6_pre_valid", int'(valid), 1);
    chk("t6_pre_type", int'(typ), int'(EVT_LONG));
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("t6_rst_valid", int'(valid), 0);
    chk("t6_rst_id", int'(id), 0);
    chk("t6_rst_type", int'(typ), 0);
    chk("t6_rst_drop", int'(drop), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready = 1'b1;
    g0 = got;
    step(10);
    lvl[1] = 1'b0;
    step(40);
    chk("t6_no_evt", got - g0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
